// File: rtl/fetch_aligner_pkg.sv
// fetch_aligner_pkg: shared types and constants for the IF-stage fetch aligner.
//   - FA_* : 2-bit aligner FSM encodings
//   - fa_state_e : typed FSM state built on those encodings
//   - next_word_addr : word-address increment, modulo 2^32
package fetch_aligner_pkg;

  localparam logic [1:0] FA_ALIGNED = 2'd0;
  localparam logic [1:0] FA_HALF    = 2'd1;
  localparam logic [1:0] FA_SKIP    = 2'd2;

  typedef enum logic [1:0] {
    StAligned = FA_ALIGNED,
    StHalf    = FA_HALF,
    StSkip    = FA_SKIP
  } fa_state_e;

  // Plain 32-bit add; carry out is discarded so 32'hFFFF_FFFC wraps to 0.
  function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_aligner.sv
// fetch_aligner: splits the 32-bit instruction-memory word stream into 16-bit (RVC) and
// 32-bit instructions, stitching 32-bit instructions that straddle two words.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   fetch_addr_o   word-aligned address of the next word to fetch
//   fetch_valid_i  fetch_rdata_i holds the word at fetch_addr_o
//   fetch_rdata_i  fetched word
//   fetch_ready_o  the word on fetch_rdata_i is consumed this cycle (when valid)
//   redirect_i     flush and restart at redirect_pc_i (highest priority)
//   redirect_pc_i  new PC, bit 0 ignored
//   instr_valid_o  instr_o / instr_pc_o valid
//   instr_ready_i  downstream accepts the instruction
//   instr_o        raw instruction, 16-bit ones zero-extended
//   instr_pc_o     PC of instr_o
module fetch_aligner
  import fetch_aligner_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] fetch_addr_o,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_rdata_i,
  output logic        fetch_ready_o,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o
);

  fa_state_e   state_q;
  logic [15:0] hbuf_q;
  logic [31:0] pc_q;
  logic [31:0] faddr_q;
  logic        instr_valid_q;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;

  logic        slot_free;
  logic        word_compressed;
  logic        hbuf_compressed;
  logic        consume;
  logic        unused_redirect_bit0;

  // Bit 0 of a redirect target carries no information for an IALIGN=16 core.
  assign unused_redirect_bit0 = redirect_pc_i[0];

  assign word_compressed = (fetch_rdata_i[1:0] != 2'b11);
  assign hbuf_compressed = (hbuf_q[1:0] != 2'b11);

  // The output register can take a new instruction if empty or being drained this cycle.
  assign slot_free = !instr_valid_q || instr_ready_i;

  always_comb begin
    fetch_ready_o = 1'b0;
    if (redirect_i) begin
      // Words from the old stream are swallowed while the redirect takes effect.
      fetch_ready_o = 1'b1;
    end else begin
      unique case (state_q)
        StAligned: fetch_ready_o = slot_free;
        // A compressed halfword in hbuf is emitted without touching the fetch port.
        StHalf:    fetch_ready_o = slot_free && !hbuf_compressed;
        // The leading halfword is discarded, so no output slot is needed.
        StSkip:    fetch_ready_o = 1'b1;
        default:   fetch_ready_o = 1'b0;
      endcase
    end
  end

  assign consume = fetch_valid_i && fetch_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= BOOT_ADDR[1] ? StSkip : StAligned;
      hbuf_q        <= 16'h0000;
      pc_q          <= {BOOT_ADDR[31:1], 1'b0};
      faddr_q       <= {BOOT_ADDR[31:2], 2'b00};
      instr_valid_q <= 1'b0;
      instr_q       <= 32'h0000_0000;
      instr_pc_q    <= BOOT_ADDR;
    end else if (redirect_i) begin
      // Pending output is dropped; instr_o / instr_pc_o keep stale contents with valid low.
      state_q       <= redirect_pc_i[1] ? StSkip : StAligned;
      hbuf_q        <= 16'h0000;
      pc_q          <= {redirect_pc_i[31:1], 1'b0};
      faddr_q       <= {redirect_pc_i[31:2], 2'b00};
      instr_valid_q <= 1'b0;
    end else begin
      if (instr_valid_q && instr_ready_i) begin
        instr_valid_q <= 1'b0;
      end
      if (consume) begin
        faddr_q <= next_word_addr(faddr_q);
      end

      unique case (state_q)
        StAligned: begin
          if (slot_free && fetch_valid_i) begin
            instr_valid_q <= 1'b1;
            instr_pc_q    <= pc_q;
            if (word_compressed) begin
              instr_q <= {16'h0000, fetch_rdata_i[15:0]};
              hbuf_q  <= fetch_rdata_i[31:16];
              pc_q    <= pc_q + 32'd2;
              state_q <= StHalf;
            end else begin
              instr_q <= fetch_rdata_i;
              pc_q    <= pc_q + 32'd4;
            end
          end
        end

        StHalf: begin
          if (slot_free) begin
            if (hbuf_compressed) begin
              instr_valid_q <= 1'b1;
              instr_pc_q    <= pc_q;
              instr_q       <= {16'h0000, hbuf_q};
              pc_q          <= pc_q + 32'd2;
              state_q       <= StAligned;
            end else if (fetch_valid_i) begin
              // Straddling 32-bit instruction: low half from hbuf, high half from the new word.
              instr_valid_q <= 1'b1;
              instr_pc_q    <= pc_q;
              instr_q       <= {fetch_rdata_i[15:0], hbuf_q};
              hbuf_q        <= fetch_rdata_i[31:16];
              pc_q          <= pc_q + 32'd4;
            end
          end
        end

        StSkip: begin
          if (fetch_valid_i) begin
            hbuf_q  <= fetch_rdata_i[31:16];
            state_q <= StHalf;
          end
        end

        default: state_q <= StAligned;
      endcase
    end
  end

  assign fetch_addr_o  = faddr_q;
  assign instr_valid_o = instr_valid_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;

endmodule
